// File: rtl/memory_loader.sv
// Write-side initiator that streams one full image into the parameter memory.
// Bytes arrive over valid/ready; outputs are registered write-port signals.
module memory_loader #(
    parameter int DEPTH  = 164,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WIDTH-1:0]  mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;

    assign s_ready = (state == LOAD) && !abort;
    assign ptr_nxt = ptr + ADDR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            mem_data <= '0;
            mem_addr <= '0;
            mem_we   <= 1'b0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            unique case (1'b1)
                (state == IDLE), (state == DONE): begin
                    // start outranks abort outside of a load
                    if (start) begin
                        state <= LOAD;
                        ptr   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                (state == LOAD): begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (s_valid) begin
                        mem_data <= s_data;
                        mem_addr <= ptr;
                        mem_we   <= 1'b1;
                        ptr      <= ptr_nxt;
                        count    <= ptr_nxt;
                        if (ptr == LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_loader.sv
// Directed bench for memory_loader with a behavioural 164x8 memory.
// Inputs change on the falling edge; outputs are checked there too.
module tb_memory_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] mem_data;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] count;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem  [0:163];
    int         wcnt [0:163];
    int         snap [0:163];

    memory_loader #(.DEPTH(164), .WIDTH(8), .ADDR_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .mem_data (mem_data),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial for (int j = 0; j < 164; j++) wcnt[j] = 0;

    always @(posedge clk) begin
        if (mem_we && mem_addr < 8'd164) begin
            mem[mem_addr]  <= mem_data;
            wcnt[mem_addr] <= wcnt[mem_addr] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic kick(input logic with_abort);
        start   = 1'b1;
        abort   = with_abort;
        s_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("kick_busy", {31'd0, busy}, 32'd1);
        chk("kick_done", {31'd0, done}, 32'd0);
        chk("kick_count", {24'd0, count}, 32'd0);
    endtask

    task automatic load_range(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i + 1);
            @(negedge clk);
            chk("ld_we", {31'd0, mem_we}, 32'd1);
            chk("ld_addr", {24'd0, mem_addr}, 32'(i));
            chk("ld_data", {24'd0, mem_data}, 32'((i + 1) & 255));
            chk("ld_count", {24'd0, count}, 32'(i + 1));
        end
        s_valid = 1'b0;
    endtask

    task automatic check_done();
        @(negedge clk);
        chk("dn_we", {31'd0, mem_we}, 32'd0);
        chk("dn_done", {31'd0, done}, 32'd1);
        chk("dn_busy", {31'd0, busy}, 32'd0);
        chk("dn_count", {24'd0, count}, 32'd164);
        chk("dn_ready", {31'd0, s_ready}, 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        @(negedge clk);
        chk("rst_outs", {mem_data, mem_addr, count, 5'd0, mem_we, busy, done},
            32'd0);
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: continuous stream
        kick(1'b0);
        load_range(0, 163);
        check_done();
        for (int j = 0; j < 164; j++)
            chk("t1_mem", {24'd0, mem[j]}, 32'((j + 1) & 255));

        // 2: s_valid toggling every cycle
        for (int j = 0; j < 164; j++) snap[j] = wcnt[j];
        kick(1'b0);
        for (int i = 0; i < 164; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i + 1);
            @(negedge clk);
            chk("t2_we_hi", {31'd0, mem_we}, 32'd1);
            chk("t2_addr", {24'd0, mem_addr}, 32'(i));
            s_valid = 1'b0;
            @(negedge clk);
            chk("t2_we_lo", {31'd0, mem_we}, 32'd0);
            chk("t2_hold", {24'd0, mem_addr}, 32'(i));
        end
        chk("t2_done", {31'd0, done}, 32'd1);
        for (int j = 0; j < 164; j++)
            chk("t2_once", 32'(wcnt[j] - snap[j]), 32'd1);

        // 3: abort together with s_valid after 10 bytes
        kick(1'b0);
        load_range(0, 9);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        abort   = 1'b1;
        #1;
        chk("t3_ready", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        abort = 1'b0;
        chk("t3_we", {31'd0, mem_we}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        chk("t3_done", {31'd0, done}, 32'd0);
        chk("t3_count", {24'd0, count}, 32'd10);
        chk("t3_addr", {24'd0, mem_addr}, 32'd9);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_idle_we", {31'd0, mem_we}, 32'd0);
            chk("t3_idle_rdy", {31'd0, s_ready}, 32'd0);
        end
        kick(1'b0);
        load_range(0, 0);

        // 4: asynchronous reset at beat 50
        load_range(1, 49);
        s_valid = 1'b1;
        s_data  = 8'd51;
        #2;
        reset = 1'b1;
        #1;
        chk("t4_outs", {mem_data, mem_addr, count, 5'd0, mem_we, busy, done},
            32'd0);
        chk("t4_ready", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        kick(1'b0);
        load_range(0, 0);

        // 5: start mid-load ignored, restarts from DONE
        load_range(1, 19);
        start = 1'b1;
        load_range(20, 20);
        start = 1'b0;
        load_range(21, 163);
        check_done();
        kick(1'b0);
        load_range(0, 163);
        check_done();
        kick(1'b1);
        load_range(0, 163);
        check_done();

        // 6: DONE ignores incoming data
        s_valid = 1'b1;
        s_data  = 8'h77;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t6_ready", {31'd0, s_ready}, 32'd0);
            @(negedge clk);
            chk("t6_we", {31'd0, mem_we}, 32'd0);
            chk("t6_addr", {24'd0, mem_addr}, 32'd163);
        end
        s_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
